// File: rtl/dma_irq_aggregator.sv
`default_nettype none
// ============================================================================
// dma_irq_aggregator: per-channel edge/level interrupt capture, enable mask
// and W1C clear behind an AXI4-Lite subordinate port.   Revision: 1.0
// ============================================================================
module dma_irq_aggregator #(
    parameter int ChannelCount = 2,
    parameter int AddrWidth    = 8
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic [ChannelCount-1:0] irq_in,
    output logic [ChannelCount-1:0] irq_out,
    output logic                    irq_any,
    input  logic [AddrWidth-1:0]    awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [31:0]             wdata,
    input  logic [3:0]              wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [AddrWidth-1:0]    araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [31:0]             rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int N = ChannelCount;

    localparam logic [2:0] c_reg_status = 3'd0;
    localparam logic [2:0] c_reg_enable = 3'd1;
    localparam logic [2:0] c_reg_clear  = 3'd2;
    localparam logic [2:0] c_reg_mode   = 3'd3;
    localparam logic [2:0] c_reg_info   = 3'd4;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] enable_q, enable_d;
    logic [N-1:0] mode_q, mode_d;
    logic         ready_en_q, ready_en_d;
    logic         bvalid_q, bvalid_d;
    logic [1:0]   bresp_q, bresp_d;
    logic         rvalid_q, rvalid_d;
    logic [1:0]   rresp_q, rresp_d;
    logic [31:0]  rdata_q, rdata_d;

    logic         wr_acc, rd_acc, wr_ok, rd_ok;
    logic [2:0]   wr_sel, rd_sel;
    logic [31:0]  lane_mask;
    logic [N-1:0] wmask, wbits, clr, set;
    logic         unused_bits;

    // Only word offsets 0x00..0x10 exist; anything above bit 4 must be zero.
    function automatic logic addr_ok(input logic [AddrWidth-1:0] a);
        return ((a >> 5) == '0) && (a[4:2] <= c_reg_info);
    endfunction

    // Ready is held off until the first edge after reset release.
    assign ready_en_d = 1'b1;
    assign wr_acc  = awvalid && wvalid && !bvalid_q && ready_en_q;
    assign rd_acc  = arvalid && !rvalid_q && ready_en_q;
    assign awready = wr_acc;
    assign wready  = wr_acc;
    assign arready = rd_acc;

    assign wr_ok  = addr_ok(awaddr);
    assign rd_ok  = addr_ok(araddr);
    assign wr_sel = awaddr[4:2];
    assign rd_sel = araddr[4:2];

    assign lane_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign wmask     = lane_mask[N-1:0];
    assign wbits     = wdata[N-1:0];
    assign unused_bits = ^{wdata, awaddr[1:0], araddr[1:0]};

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        clr      = '0;
        if (wr_acc && wr_ok) begin
            case (wr_sel)
                c_reg_enable: enable_d = (enable_q & ~wmask) | (wbits & wmask);
                c_reg_clear:  clr      = wbits & wmask;
                c_reg_mode:   mode_d   = (mode_q & ~wmask) | (wbits & wmask);
                default:      ;
            endcase
        end
        // A new capture overrides a same-edge clear.
        set       = irq_in & ~(mode_q & prev_q);
        pending_d = (pending_q & ~clr) | set;
        prev_d    = irq_in;
    end

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_acc) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? c_resp_okay : c_resp_slverr;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rd_acc) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_ok ? c_resp_okay : c_resp_slverr;
            rdata_d  = '0;
            if (rd_ok) begin
                case (rd_sel)
                    c_reg_status: rdata_d = 32'(pending_q);
                    c_reg_enable: rdata_d = 32'(enable_q);
                    c_reg_mode:   rdata_d = 32'(mode_q);
                    c_reg_info:   rdata_d = {26'd0, 6'(ChannelCount)};
                    default:      rdata_d = '0;
                endcase
            end
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pending_q  <= '0;
            prev_q     <= '0;
            enable_q   <= '0;
            mode_q     <= '1;
            ready_en_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            prev_q     <= prev_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            ready_en_q <= ready_en_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign irq_out = pending_q & enable_q;
    assign irq_any = |irq_out;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_irq_aggregator.sv
`default_nettype none
// ============================================================================
// tb_dma_irq_aggregator: directed and randomized bench with a behavioural
// per-channel model of capture, masking and the register map. Revision: 1.0
// ============================================================================
module tb_dma_irq_aggregator;
    logic        clk = 1'b0;
    logic        areset_n;
    logic [1:0]  irq_in;
    logic [1:0]  irq_out;
    logic        irq_any;
    logic [7:0]  awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [7:0]  araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state.
    bit [1:0]    m_pend, m_prev, m_en, m_mode;
    bit          wr_now;
    logic [7:0]  wr_a;
    logic [31:0] wr_d;
    logic [3:0]  wr_s;

    dma_irq_aggregator #(.ChannelCount(2), .AddrWidth(8)) dut (
        .clk(clk), .areset_n(areset_n), .irq_in(irq_in), .irq_out(irq_out),
        .irq_any(irq_any), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready), .araddr(araddr),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_valid(input logic [7:0] a);
        return a < 8'h14;
    endfunction

    task automatic model_reset();
        m_pend = 2'b00; m_prev = 2'b00; m_en = 2'b00; m_mode = 2'b11; wr_now = 1'b0;
    endtask

    task automatic model_edge();
        bit [1:0] nxt;
        bit s, c;
        int word;
        word = int'(wr_a) / 4;
        for (int ch = 0; ch < 2; ch++) begin
            if (m_mode[ch]) s = irq_in[ch] && !m_prev[ch];
            else            s = irq_in[ch];
            c = wr_now && addr_valid(wr_a) && word == 2 && wr_d[ch] && wr_s[ch / 8];
            if (s)      nxt[ch] = 1'b1;
            else if (c) nxt[ch] = 1'b0;
            else        nxt[ch] = m_pend[ch];
            if (wr_now && addr_valid(wr_a) && wr_s[ch / 8]) begin
                if (word == 1) m_en[ch]   = wr_d[ch];
                if (word == 3) m_mode[ch] = wr_d[ch];
            end
        end
        m_pend = nxt;
        m_prev = irq_in;
        wr_now = 1'b0;
    endtask

    task automatic exp_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        d = 32'd0;
        r = 2'b10;
        if (addr_valid(a)) begin
            r = 2'b00;
            case (int'(a) / 4)
                0: d = {30'd0, m_pend};
                1: d = {30'd0, m_en};
                3: d = {30'd0, m_mode};
                4: d = 32'd2;
                default: d = 32'd0;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_irq();
        chk("irq_out", irq_out, m_pend & m_en);
        chk("irq_any", irq_any, |(m_pend & m_en));
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [31:0] ed;
        logic [1:0]  er;
        araddr = a; arvalid = 1'b1;
        exp_read(a, ed, er);
        @(negedge clk);
        chk("arready", arready, 1'b1);
        cyc();
        arvalid = 1'b0;
        chk("rvalid", rvalid, 1'b1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        logic [1:0] er;
        er = addr_valid(a) ? 2'b00 : 2'b10;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("aw_w_ready", {awready, wready}, 2'b11);
        wr_now = 1'b1; wr_a = a; wr_d = d; wr_s = s;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", bvalid, 1'b1);
        chk("bresp", bresp, er);
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk("b_hold", {bvalid, bresp}, {1'b1, er});
        end
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 1'b0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] bases [8];
        bases[0] = 8'h00; bases[1] = 8'h04; bases[2] = 8'h08; bases[3] = 8'h0C;
        bases[4] = 8'h10; bases[5] = 8'h14; bases[6] = 8'h1C; bases[7] = 8'h40;

        areset_n = 1'b0; irq_in = 2'b00;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq_out", irq_out, 2'b00);
        chk("rst_valids", {bvalid, rvalid, awready, arready}, 4'b0000);
        areset_n = 1'b1;
        cyc(); cyc();

        do_read(8'h00);
        do_read(8'h04);
        do_read(8'h0C);
        do_read(8'h10);
        chk_irq();

        // Edge capture and masking.
        do_write(8'h04, 32'h1, 4'hF, 0);
        irq_in = 2'b11; cyc();
        irq_in = 2'b00; cyc();
        chk("edge_irq_out", irq_out, 2'b01);
        chk("edge_irq_any", irq_any, 1'b1);
        do_read(8'h00);
        do_write(8'h08, 32'h1, 4'hF, 0);
        do_read(8'h00);
        chk("clr_irq_any", irq_any, 1'b0);

        // Capture on the same edge as a clear wins.
        irq_in = 2'b01; cyc();
        irq_in = 2'b00; cyc();
        irq_in = 2'b01;
        do_write(8'h08, 32'h1, 4'hF, 0);
        irq_in = 2'b00;
        do_read(8'h00);
        chk("collision_bit0", m_pend[0], 1'b1);
        do_write(8'h08, 32'h3, 4'hF, 0);
        do_read(8'h00);

        // Level mode: clear cannot stick while the source is high.
        do_write(8'h0C, 32'h0, 4'hF, 0);
        irq_in = 2'b10; cyc();
        do_write(8'h08, 32'h2, 4'hF, 0);
        do_read(8'h00);
        irq_in = 2'b00; cyc();
        do_write(8'h08, 32'h2, 4'hF, 0);
        do_read(8'h00);
        do_write(8'h0C, 32'h3, 4'hF, 0);

        // Disabled byte lane leaves ENABLE untouched.
        do_write(8'h04, 32'h3, 4'b1110, 0);
        do_read(8'h04);

        // Lone awvalid is never accepted; bad address gives SLVERR.
        awaddr = 8'h1C; awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lone_aw", awready, 1'b0);
            cyc();
        end
        do_write(8'h1C, 32'hDEAD, 4'hF, 4);
        do_read(8'h1C);

        // Randomized traffic against the model.
        for (int it = 0; it < 120; it++) begin
            irq_in = 2'($urandom_range(0, 3));
            a = bases[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: cyc();
                1: do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
                2: do_read(a);
                default: do_read(8'h00);
            endcase
            chk_irq();
        end

        // Asynchronous reset while a read response is outstanding.
        irq_in = 2'b00; cyc();
        do_write(8'h0C, 32'h3, 4'hF, 0);
        do_write(8'h04, 32'h3, 4'hF, 0);
        irq_in = 2'b01; cyc();
        irq_in = 2'b00; cyc();
        chk("pre_rst_irq_any", irq_any, 1'b1);
        araddr = 8'h00; arvalid = 1'b1;
        @(negedge clk);
        cyc();
        arvalid = 1'b0;
        chk("pre_rst_rvalid", rvalid, 1'b1);
        #2 areset_n = 1'b0;
        #1;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_irq", {irq_out, irq_any}, 3'b000);
        model_reset();
        repeat (2) @(posedge clk);
        #1 areset_n = 1'b1;
        cyc(); cyc();
        do_read(8'h00);
        chk("post_rst_status", rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
